// File: rtl/if_stage_if.sv
// Instruction-memory port of the fetch stage: one outstanding read request, one returned doubleword.
// Handshake: a request transfers when imem_req_valid && imem_req_ready; imem_rvalid qualifies imem_rdata for one cycle.
interface if_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [63:0] imem_rdata;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one request in flight, instruction latched one cycle after imem_rvalid,
// offered to ID until accepted; flush redirects, isebreak halts until reset.
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000000080000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipeline_flush,
  input  logic [63:0]      redirect_pc,
  input  logic             isebreak,
  if_stage_if.master       imem,
  output logic [63:0]      if_pc,
  output logic [31:0]      if_inst,
  output logic             if_valid,
  output logic             if_ready_go,
  input  logic             id_allow_in,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_HOLD = 3'd2,
    S_DROP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (state_q == S_HALT) begin
      state_d = S_HALT;
    end else if (isebreak) begin
      state_d = S_HALT;
    end else if (pipeline_flush) begin
      // A response arriving in the flush cycle closes the outstanding read, so no DROP is needed.
      pc_d = redirect_pc;
      case (state_q)
        S_WAIT:  state_d = imem.imem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state_d = imem.imem_rvalid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem.imem_req_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            inst_d  = pc_q[2] ? imem.imem_rdata[63:32] : imem.imem_rdata[31:0];
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (id_allow_in) begin
            pc_d    = pc_q + 64'd4;
            state_d = S_REQ;
          end
        end
        S_DROP: begin
          if (imem.imem_rvalid) state_d = S_REQ;
        end
        default: state_d = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // Request is masked while reset is held so no handshake can start a read that reset would orphan.
  assign imem.imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem.imem_addr      = pc_q;
  assign if_pc               = pc_q;
  assign if_inst             = inst_q;
  assign if_valid            = (state_q == S_WAIT) || (state_q == S_HOLD);
  assign if_ready_go         = (state_q == S_HOLD);
  assign dbg_state           = state_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0000000080000000, is the first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pipeline_flush  input  1  redirect request from a jump or interrupt; discards the in-flight fetch.
REQ-005 redirect_pc  input  64  new fetch PC; valid when pipeline_flush=1.
REQ-006 isebreak  input  1  halt request; stops fetching until rst.
REQ-007 imem_req_valid  output  1  instruction memory read request.
REQ-008 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-009 imem_addr  output  64  request address, always equal to the current fetch PC.
REQ-010 imem_rvalid  input  1  read data returned this cycle.
REQ-011 imem_rdata  input  64  doubleword read data, 8-byte aligned.
REQ-012 if_pc  output  64  PC of the instruction offered to ID.
REQ-013 if_inst  output  32  instruction offered to ID.
REQ-014 if_valid  output  1  IF holds a live fetch slot.
REQ-015 if_ready_go  output  1  if_inst is available for transfer.
REQ-016 id_allow_in  input  1  ID accepts an instruction this cycle.

Function
REQ-017 The block SHALL be a five-state FSM: REQ, WAIT, HOLD, DROP, HALT; a single fetch PC register drives both imem_addr and if_pc.
REQ-018 Event priority SHALL be rst > isebreak > pipeline_flush > normal transitions.
REQ-019 REQ: imem_req_valid=1; on imem_req_ready go to WAIT; with no handshake, stay in REQ and hold imem_addr stable.
REQ-020 WAIT: imem_req_valid=0, if_valid=1, if_ready_go=0; on imem_rvalid latch the instruction and go to HOLD.
REQ-021 Instruction select: imem_rdata[63:32] when pc[2]=1, else imem_rdata[31:0].
REQ-022 HOLD: if_valid=1, if_ready_go=1; when id_allow_in=1, the transfer occurs that cycle, pc<=pc+4 (64-bit wrap, no overflow flag), next state REQ.
REQ-023 HOLD with id_allow_in=0: if_pc and if_inst SHALL stay unchanged for any number of cycles.
REQ-024 DROP: if_valid=0, if_ready_go=0, no new request; the next imem_rvalid is discarded and the next state is REQ.
REQ-025 Flush in REQ or HOLD: pc<=redirect_pc, next state REQ; a HOLD instruction is not transferred even if id_allow_in=1.
REQ-026 Flush in WAIT without imem_rvalid that cycle: pc<=redirect_pc, next state DROP.
REQ-027 Flush in WAIT with imem_rvalid the same cycle: discard the data, pc<=redirect_pc, next state REQ.
REQ-028 Flush in DROP: pc<=redirect_pc, stay in DROP; if imem_rvalid arrives the same cycle, go to REQ.
REQ-029 isebreak in any state: go to HALT and drop any held or pending instruction.
REQ-030 HALT: imem_req_valid=0, if_valid=0, if_ready_go=0; ignore imem_rvalid, pipeline_flush and isebreak; leave only via rst.
REQ-031 At most one memory request SHALL be outstanding; a new request is never issued before the previous response is consumed or dropped.
REQ-032 imem_rvalid seen in REQ or HOLD SHALL be ignored.
REQ-033 Fetch-to-offer latency SHALL be one cycle after imem_rvalid; there is no combinational path from imem_rdata to if_inst.

Reset
REQ-034 On rst: state=REQ, pc=RESET_PC, if_inst=32'h0, if_valid=0, if_ready_go=0; imem_req_valid=1 from the first cycle after reset deasserts.
REQ-035 rst in WAIT SHALL abandon the outstanding response; the first imem_rvalid after reset, arriving before any new handshake, SHALL be ignored.

Verification
REQ-036 Reset, req_ready=1, rvalid 1 cycle later with rdata=64'h00100073_00000013, id_allow_in=1 -> imem_addr=0x80000000, if_inst=0x00000013 offered; next request at 0x80000004 selects 0x00100073.
REQ-037 HOLD with id_allow_in=0 for 5 cycles -> if_pc and if_inst stable, no request issued; raising id_allow_in -> one transfer, then request at pc+4.
REQ-038 Flush with redirect_pc=0x80001000 in WAIT, rvalid 3 cycles later with junk data -> data dropped, no if_ready_go, next request at 0x80001000.
REQ-039 Flush and imem_rvalid in the same WAIT cycle -> no DROP state, request at redirect_pc on the next cycle.
REQ-040 isebreak in HOLD with id_allow_in=1 -> no transfer, HALT entered, all outputs quiet despite later flush or rvalid; only rst restarts fetch at RESET_PC.
